// File: rtl/booth_mul_seq_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
// The early-termination feature is selected by BOOTH_EARLY_TERM_EN in booth_mul_seq.sv.
package booth_mul_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    typedef enum logic [2:0] {ZERO, PQ, P2Q, NQ, N2Q} recode_t;

    // bits = {m[1], m[0], carry-in from the previous pair}
    function automatic recode_t booth_recode(input logic [2:0] bits);
        recode_t sel;
        case (bits)
            3'b001, 3'b010: sel = PQ;
            3'b011:         sel = P2Q;
            3'b100:         sel = N2Q;
            3'b101, 3'b110: sel = NQ;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_mul_seq_r4_step.sv
// One combinational radix-4 Booth step: recode, then add into the WIDTH+2 bit accumulator.
module booth_r4_step
    import booth_mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       bits,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH+1:0] acc,
    output logic [WIDTH+1:0] acc_next
);

    logic [WIDTH+1:0] q_ext;
    logic [WIDTH+1:0] addend;

    // Two guard bits hold +-2Q and the running sum without overflow.
    assign q_ext = {{2{q[WIDTH-1]}}, q};

    always_comb begin
        addend = '0;
        case (booth_recode(bits))
            PQ:      addend = q_ext;
            P2Q:     addend = q_ext << 1;
            NQ:      addend = -q_ext;
            N2Q:     addend = -(q_ext << 1);
            default: addend = '0;
        endcase
    end

    assign acc_next = acc + addend;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-4 Booth multiplier, WIDTH/2 iterations.
// Define BOOTH_EARLY_TERM_EN to finish as soon as the remaining multiplier bits recode to zero.
module booth_mul_seq
    import booth_mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   Q,
    input  logic [WIDTH-1:0]   M,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int N  = WIDTH / 2;
    localparam int CW = $clog2(N + 1);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH+1:0]   acc;
    logic [WIDTH+1:0]   acc_step;
    logic               carry;
    logic [CW-1:0]      count;
    logic [2*WIDTH+1:0] shifted;
    logic               last_step;
    logic               step_done;
    logic [2*WIDTH-1:0] result;

    booth_r4_step #(.WIDTH(WIDTH)) u_step (
        .bits     ({sreg[1:0], carry}),
        .q        (q_r),
        .acc      (acc),
        .acc_next (acc_step)
    );

    // {acc, sreg} arithmetic right shift by one Booth digit
    assign shifted   = {{2{acc_step[WIDTH+1]}}, acc_step, sreg[WIDTH-1:2]};
    assign last_step = (count == CW'(N - 1));

`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem_mask;
    logic               early;
    logic [2*WIDTH+1:0] flushed;

    // Low WIDTH-2*count bits of sreg are the multiplier bits not yet consumed.
    assign rem_mask = {WIDTH{1'b1}} >> (2 * int'(count));
    assign early    = (((sreg & rem_mask) == '0) && !carry) ||
                      (((sreg | ~rem_mask) == '1) && carry);
    assign flushed  = $signed({acc, sreg}) >>> (2 * (N - int'(count)));

    assign step_done = early || last_step;
    assign result    = early ? flushed[2*WIDTH-1:0] : shifted[2*WIDTH-1:0];
`else
    assign step_done = last_step;
    assign result    = shifted[2*WIDTH-1:0];
`endif

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                busy     = 1'b1;
                state_nx = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (step_done) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            q_r   <= '0;
            sreg  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            prod  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                // M goes straight into the shift register; LOAD leaves it untouched.
                IDLE: if (start) begin
                    q_r  <= Q;
                    sreg <= M;
                end
                LOAD: begin
                    acc   <= '0;
                    carry <= 1'b0;
                    count <= '0;
                end
                ITER: begin
                    acc   <= shifted[2*WIDTH+1:WIDTH];
                    sreg  <= shifted[WIDTH-1:0];
                    carry <= sreg[1];
                    count <= count + CW'(1);
                    if (step_done) prod <= result;
                end
                default: ;
            endcase
        end
    end

endmodule
